// File: rtl/mc_pkg.sv
// Shared types and encodings for the RV32I multicycle control unit.
package mc_pkg;

   localparam int unsigned OP_W   = 7;
   localparam int unsigned F3_W   = 3;
   localparam int unsigned ALUC_W = 3;
   localparam int unsigned SEL_W  = 2;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECR, EXECI, ALUWB, JAL, BRANCH, TRAP
   } state_t;

   localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
   localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
   localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
   localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
   localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;
   localparam logic [OP_W-1:0] OP_BR  = 7'b1100011;

   localparam logic [ALUC_W-1:0] ALUC_ADD = 3'b000;
   localparam logic [ALUC_W-1:0] ALUC_SUB = 3'b001;
   localparam logic [ALUC_W-1:0] ALUC_AND = 3'b010;
   localparam logic [ALUC_W-1:0] ALUC_OR  = 3'b011;
   localparam logic [ALUC_W-1:0] ALUC_SLT = 3'b101;

   localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [SEL_W-1:0] IMM_I = 2'b00;
   localparam logic [SEL_W-1:0] IMM_S = 2'b01;
   localparam logic [SEL_W-1:0] IMM_B = 2'b10;
   localparam logic [SEL_W-1:0] IMM_J = 2'b11;

   localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
   localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
   localparam logic [SEL_W-1:0] SRCA_RD1   = 2'b10;

   localparam logic [SEL_W-1:0] SRCB_RD2  = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

   localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
   localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
   localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

   function automatic logic is_mem_state(input state_t s);
      return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
   endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU operation decode from ALUOp/funct3/funct7b5; flags funct3 values the ALU does not support.
module mc_alu_decoder
   import mc_pkg::*;
(
   input  logic [OP_W-1:0]   op,
   input  logic [F3_W-1:0]   funct3,
   input  logic              funct7b5,
   input  logic [SEL_W-1:0]  ALUOp,
   output logic [ALUC_W-1:0] ALUControl,
   output logic              illegal
);

   logic w_rsub;

   // Only register-register ops use bit 30 to select sub; addi ignores it.
   assign w_rsub = (op == OP_R) && funct7b5;

   always_comb begin
      illegal = 1'b0;
      case (funct3)
         3'b000, 3'b010, 3'b110, 3'b111: illegal = 1'b0;
         default:                        illegal = 1'b1;
      endcase
   end

   always_comb begin
      ALUControl = ALUC_ADD;
      case (ALUOp)
         ALUOP_ADD: ALUControl = ALUC_ADD;
         ALUOP_SUB: ALUControl = ALUC_SUB;
         default: begin
            case (funct3)
               3'b000:  ALUControl = w_rsub ? ALUC_SUB : ALUC_ADD;
               3'b010:  ALUControl = ALUC_SLT;
               3'b110:  ALUControl = ALUC_OR;
               3'b111:  ALUControl = ALUC_AND;
               default: ALUControl = ALUC_ADD;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RV32I controller: datapath enables/mux selects, memory ready handshake
// with wait-state timeout, full branch compares and a sticky trap.
module mc_control_unit
   import mc_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 15,
   parameter int unsigned BR_FULL      = 1,
   parameter int unsigned WCNT_W       = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [OP_W-1:0]   op,
   input  logic [F3_W-1:0]   funct3,
   input  logic              funct7b5,
   input  logic              Zero,
   input  logic              Lt,
   input  logic              Ltu,
   input  logic              mem_ready,
   output logic              mem_req,
   output logic              PCWrite,
   output logic              AdrSrc,
   output logic              MemWrite,
   output logic              IRWrite,
   output logic              RegWrite,
   output logic [SEL_W-1:0]  ResultSrc,
   output logic [SEL_W-1:0]  ALUSrcA,
   output logic [SEL_W-1:0]  ALUSrcB,
   output logic [SEL_W-1:0]  ImmSrc,
   output logic [ALUC_W-1:0] ALUControl,
   output logic              trap
);

   localparam logic [WCNT_W-1:0] LP_WLIMIT = WCNT_W'(MEM_WAIT_MAX - 1);
   localparam bit                LP_TMO_EN = (MEM_WAIT_MAX != 0);

   state_t            r_state;
   state_t            w_next;
   logic [WCNT_W-1:0] r_wcnt;
   logic              r_trap;

   logic [SEL_W-1:0]  w_aluop;
   logic              w_alu_illegal;
   logic              w_br_taken;
   logic              w_br_illegal;
   logic              w_mem_state;
   logic              w_timeout;
   logic              w_pcwrite;
   logic              w_irwrite;
   logic              w_regwrite;
   logic              w_memwrite;

   mc_alu_decoder u_alu_dec (
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .ALUOp      (w_aluop),
      .ALUControl (ALUControl),
      .illegal    (w_alu_illegal)
   );

   always_comb begin
      w_br_taken   = 1'b0;
      w_br_illegal = 1'b0;
      case (funct3)
         3'b000:  w_br_taken = Zero;
         3'b001:  w_br_taken = !Zero;
         3'b100:  w_br_taken = Lt;
         3'b101:  w_br_taken = !Lt;
         3'b110:  w_br_taken = Ltu;
         3'b111:  w_br_taken = !Ltu;
         default: w_br_illegal = 1'b1;
      endcase
      if ((BR_FULL == 0) && funct3[2]) begin
         w_br_illegal = 1'b1;
      end
   end

   // The limit is hit when this stalled cycle would make the count reach MEM_WAIT_MAX.
   assign w_mem_state = is_mem_state(r_state);
   assign w_timeout   = LP_TMO_EN && w_mem_state && !mem_ready && (r_wcnt == LP_WLIMIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Wait counter restarts on every state change, so each memory state begins at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wcnt <= '0;
      end else if (w_next != r_state) begin
         r_wcnt <= '0;
      end else if (w_mem_state && !mem_ready && (r_wcnt != '1)) begin
         r_wcnt <= r_wcnt + WCNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_trap <= 1'b0;
      end else begin
         r_trap <= r_trap | (w_next == TRAP);
      end
   end

   always_comb begin
      w_next     = r_state;
      mem_req    = 1'b0;
      w_pcwrite  = 1'b0;
      AdrSrc     = 1'b0;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      w_regwrite = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RD2;
      ImmSrc     = IMM_I;
      w_aluop    = ALUOP_ADD;
      case (r_state)
         FETCH: begin
            mem_req   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            if (mem_ready) begin
               w_irwrite = 1'b1;
               w_pcwrite = 1'b1;
               w_next    = DECODE;
            end else if (w_timeout) begin
               w_next = TRAP;
            end
         end
         DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = IMM_B;
            case (op)
               OP_LW, OP_SW: w_next = MEMADR;
               OP_R:         w_next = w_alu_illegal ? TRAP : EXECR;
               OP_I:         w_next = w_alu_illegal ? TRAP : EXECI;
               OP_JAL:       w_next = JAL;
               OP_BR:        w_next = w_br_illegal ? TRAP : BRANCH;
               default:      w_next = TRAP;
            endcase
         end
         MEMADR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = (op == OP_SW) ? IMM_S : IMM_I;
            w_next  = (op == OP_SW) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            mem_req = 1'b1;
            AdrSrc  = 1'b1;
            if (mem_ready) begin
               w_next = MEMWB;
            end else if (w_timeout) begin
               w_next = TRAP;
            end
         end
         MEMWB: begin
            ResultSrc  = RES_DATA;
            w_regwrite = 1'b1;
            w_next     = FETCH;
         end
         MEMWRITE: begin
            mem_req    = 1'b1;
            AdrSrc     = 1'b1;
            w_memwrite = 1'b1;
            if (mem_ready) begin
               w_next = FETCH;
            end else if (w_timeout) begin
               w_next = TRAP;
            end
         end
         EXECR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_RD2;
            w_aluop = ALUOP_FUNCT;
            w_next  = ALUWB;
         end
         EXECI: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            w_aluop = ALUOP_FUNCT;
            w_next  = ALUWB;
         end
         ALUWB: begin
            w_regwrite = 1'b1;
            w_next     = FETCH;
         end
         JAL: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            w_pcwrite = 1'b1;
            w_next    = ALUWB;
         end
         BRANCH: begin
            ALUSrcA   = SRCA_RD1;
            ALUSrcB   = SRCB_RD2;
            w_aluop   = ALUOP_SUB;
            w_pcwrite = w_br_taken;
            w_next    = FETCH;
         end
         TRAP: begin
            w_next = TRAP;
         end
         default: begin
            w_next = FETCH;
         end
      endcase
   end

   // Write enables are forced low while reset is held, independent of the state decode.
   assign PCWrite  = w_pcwrite  & ~reset;
   assign IRWrite  = w_irwrite  & ~reset;
   assign RegWrite = w_regwrite & ~reset;
   assign MemWrite = w_memwrite & ~reset;
   assign trap     = r_trap;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit; a second instance with BR_FULL=0 covers the reduced branch set.
module tb_mc_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero, Lt, Ltu, mem_ready;

   logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, trap;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;

   logic       nb_mem_req, nb_PCWrite, nb_AdrSrc, nb_MemWrite, nb_IRWrite, nb_RegWrite, nb_trap;
   logic [1:0] nb_ResultSrc, nb_ALUSrcA, nb_ALUSrcB, nb_ImmSrc;
   logic [2:0] nb_ALUControl;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mc_control_unit #(.MEM_WAIT_MAX(15), .BR_FULL(1), .WCNT_W(4)) dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
      .mem_req(mem_req), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .trap(trap)
   );

   mc_control_unit #(.MEM_WAIT_MAX(15), .BR_FULL(0), .WCNT_W(4)) dut_nb (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
      .mem_req(nb_mem_req), .PCWrite(nb_PCWrite), .AdrSrc(nb_AdrSrc), .MemWrite(nb_MemWrite),
      .IRWrite(nb_IRWrite), .RegWrite(nb_RegWrite), .ResultSrc(nb_ResultSrc), .ALUSrcA(nb_ALUSrcA),
      .ALUSrcB(nb_ALUSrcB), .ImmSrc(nb_ImmSrc), .ALUControl(nb_ALUControl), .trap(nb_trap)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Leaves the bench 1 time unit into cycle 1 (first FETCH cycle).
   task automatic do_reset(input logic [6:0] i_op, input logic [2:0] i_f3, input logic i_f7);
      reset = 1'b1; op = i_op; funct3 = i_f3; funct7b5 = i_f7;
      Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Per-cycle traces of the write enables; bit c holds cycle c+1.
   task automatic run_trace(input string tag, input int n, input logic [31:0] rdy,
                            input logic [31:0] e_ir, input logic [31:0] e_pc,
                            input logic [31:0] e_rw, input logic [31:0] e_mw);
      logic [31:0] g_ir, g_pc, g_rw, g_mw;
      g_ir = '0; g_pc = '0; g_rw = '0; g_mw = '0;
      for (int c = 0; c < n; c++) begin
         mem_ready = rdy[c];
         #1;
         g_ir[c] = IRWrite; g_pc[c] = PCWrite; g_rw[c] = RegWrite; g_mw[c] = MemWrite;
         step();
      end
      check_eq({tag, "_irwrite"},  g_ir, e_ir);
      check_eq({tag, "_pcwrite"},  g_pc, e_pc);
      check_eq({tag, "_regwrite"}, g_rw, e_rw);
      check_eq({tag, "_memwrite"}, g_mw, e_mw);
   endtask

   initial begin
      // Enables held low during reset even with mem_ready high in FETCH
      reset = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
      Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0; mem_ready = 1'b1;
      @(posedge clk); #2;
      check_eq("rst_irwrite",  32'(IRWrite),  32'd0);
      check_eq("rst_pcwrite",  32'(PCWrite),  32'd0);
      check_eq("rst_trap",     32'(trap),     32'd0);
      check_eq("rst_mem_req",  32'(mem_req),  32'd1);
      check_eq("rst_alusrcb",  32'(ALUSrcB),  32'd2);

      // add x3,x1,x2
      do_reset(7'b0110011, 3'b000, 1'b0);
      run_trace("add", 4, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h8, 32'h0);

      do_reset(7'b0110011, 3'b000, 1'b0);
      #1;
      check_eq("fetch_ressrc", 32'(ResultSrc), 32'd2);
      step(); #1;
      check_eq("decode_srca", 32'(ALUSrcA), 32'd1);
      check_eq("decode_imm",  32'(ImmSrc),  32'd2);
      step(); #1;
      check_eq("add_aluctl", 32'(ALUControl), 32'd0);
      check_eq("add_srca",   32'(ALUSrcA),    32'd2);

      do_reset(7'b0110011, 3'b000, 1'b1);
      step(); step(); #1;
      check_eq("sub_aluctl", 32'(ALUControl), 32'd1);

      do_reset(7'b0010011, 3'b000, 1'b1);
      step(); step(); #1;
      check_eq("addi_aluctl", 32'(ALUControl), 32'd0);
      check_eq("addi_srcb",   32'(ALUSrcB),    32'd1);

      do_reset(7'b0110011, 3'b111, 1'b0);
      step(); step(); #1;
      check_eq("and_aluctl", 32'(ALUControl), 32'd2);

      // lw: 3 FETCH waits, 2 MEMREAD waits
      do_reset(7'b0000011, 3'b010, 1'b0);
      run_trace("lw", 10, 32'h338, 32'h8, 32'h8, 32'h200, 32'h0);
      check_eq("lw_trap", 32'(trap), 32'd0);

      // blt taken; reduced-branch instance must trap
      do_reset(7'b1100011, 3'b100, 1'b0);
      Lt = 1'b1;
      run_trace("blt", 3, 32'hFFFF_FFFF, 32'h1, 32'h5, 32'h0, 32'h0);
      #1;
      check_eq("blt_trap",    32'(trap),    32'd0);
      check_eq("blt_nb_trap", 32'(nb_trap), 32'd1);

      // bgeu with Ltu=1 not taken
      do_reset(7'b1100011, 3'b111, 1'b0);
      Ltu = 1'b1;
      run_trace("bgeu", 3, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0, 32'h0);

      // beq legal in both variants
      do_reset(7'b1100011, 3'b000, 1'b0);
      Zero = 1'b1;
      run_trace("beq", 3, 32'hFFFF_FFFF, 32'h1, 32'h5, 32'h0, 32'h0);
      #1;
      check_eq("beq_nb_trap", 32'(nb_trap), 32'd0);

      // jal
      do_reset(7'b1101111, 3'b000, 1'b0);
      run_trace("jal", 4, 32'hFFFF_FFFF, 32'h1, 32'h5, 32'h8, 32'h0);

      // sw timeout: MEMWRITE cycles 4..18, TRAP from cycle 19
      do_reset(7'b0100011, 3'b010, 1'b0);
      run_trace("sw_tmo", 20, 32'h1, 32'h1, 32'h1, 32'h0, 32'h3FFF8);
      #1;
      check_eq("sw_tmo_trap",     32'(trap),     32'd1);
      check_eq("sw_tmo_memwrite", 32'(MemWrite), 32'd0);
      check_eq("sw_tmo_mem_req",  32'(mem_req),  32'd0);

      // mem_ready on the 15th wait cycle completes normally
      do_reset(7'b0100011, 3'b010, 1'b0);
      run_trace("sw_edge", 20, 32'h2_0001, 32'h1, 32'h1, 32'h0, 32'h3FFF8);
      #1;
      check_eq("sw_edge_trap",    32'(trap),    32'd0);
      check_eq("sw_edge_mem_req", 32'(mem_req), 32'd1);

      // illegal opcode
      do_reset(7'b0000000, 3'b000, 1'b0);
      run_trace("illop", 3, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0, 32'h0);
      #1;
      check_eq("illop_trap",    32'(trap),    32'd1);
      check_eq("illop_irwrite", 32'(IRWrite), 32'd0);

      // illegal ALU funct3
      do_reset(7'b0110011, 3'b001, 1'b0);
      step(); step(); #1;
      check_eq("illf3_trap", 32'(trap), 32'd1);

      // reset pulse mid-MEMWRITE
      do_reset(7'b0100011, 3'b010, 1'b0);
      run_trace("sw_rst", 6, 32'h1, 32'h1, 32'h1, 32'h0, 32'h38);
      mem_ready = 1'b0;
      #1;
      check_eq("sw_rst_before", 32'(MemWrite), 32'd1);
      reset = 1'b1;
      #1;
      check_eq("sw_rst_memwrite", 32'(MemWrite), 32'd0);
      check_eq("sw_rst_mem_req",  32'(mem_req),  32'd1);
      check_eq("sw_rst_adrsrc",   32'(AdrSrc),   32'd0);
      step();
      reset = 1'b0; mem_ready = 1'b1;
      #1;
      check_eq("sw_rst_refetch", 32'(IRWrite), 32'd1);
      check_eq("sw_rst_trap",    32'(trap),    32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
